// File: rtl/fp32_pkg.sv
// float32 field constants, named literals and integrator FSM states.
// Shared by the spike integrator and the fp_ge comparator.
package fp32_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CHK  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_spike_integrator_if.sv
// Valid/ready stream of float32 synaptic contributions.
// master drives in_valid/in_value, slave returns in_ready.
interface fp_spike_integrator_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;

  modport master (
    output in_valid,
    output in_value,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_value,
    output in_ready
  );

endinterface

// File: rtl/fp_ge.sv
// Combinational float32 a >= b, sign-magnitude, +0 == -0.
// Ports: a, b [31:0] in; ge out. NaN/Inf not handled.
module fp_ge
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ge
);

  logic [EXP_MSB:0] ma;
  logic [EXP_MSB:0] mb;
  logic             az;
  logic             bz;
  logic             sa;
  logic             sb;

  assign ma = a[EXP_MSB:0];
  assign mb = b[EXP_MSB:0];
  assign az = (a[EXP_MSB:EXP_LSB] == '0)
           && (a[MAN_W-1:0] == '0);
  assign bz = (b[EXP_MSB:EXP_LSB] == '0)
           && (b[MAN_W-1:0] == '0);

  // A zero of either sign is treated as +0.
  assign sa = a[SIGN_BIT] & ~az;
  assign sb = b[SIGN_BIT] & ~bz;

  always_comb begin
    ge = 1'b0;
    unique case ({sa, sb})
      2'b00: ge = (ma >= mb);
      2'b01: ge = 1'b1;
      2'b10: ge = 1'b0;
      2'b11: ge = (ma <= mb);
      default: ge = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_spike_integrator.sv
// float32 membrane integrator: adds contributions/leak via external adder, fires at threshold.
// Ports: clk, rst_n, in_if (slave stream), tick, add_b/add_c/add_a, v_mem, spike, spike_cnt, busy.
module fp_spike_integrator
  import fp32_pkg::*;
#(
  parameter logic [31:0] THRESHOLD = FP_ONE,
  parameter logic [31:0] V_RESET   = FP_ZERO,
  parameter logic [31:0] LEAK      = 32'hBC23_D70A,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_spike_integrator_if.slave in_if,
  input  logic             tick,
  output logic [31:0]      add_b,
  output logic [31:0]      add_c,
  input  logic [31:0]      add_a,
  output logic [31:0]      v_mem,
  output logic             spike,
  output logic [CNT_W-1:0] spike_cnt,
  output logic             busy
);

  state_t           state;
  logic [31:0]      v_q;
  logic [31:0]      op_q;
  logic             pend_q;
  logic             spike_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ge;

  fp_ge u_ge (
    .a  (v_q),
    .b  (THRESHOLD),
    .ge (ge)
  );

  assign add_b     = v_q;
  assign add_c     = op_q;
  assign v_mem     = v_q;
  assign spike     = spike_q;
  assign spike_cnt = cnt_q;
  assign busy      = (state != IDLE);

  // A tick (live or pending) owns the adder, so the stream stalls.
  assign in_if.in_ready = (state == IDLE)
                        && !tick && !pend_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      v_q     <= V_RESET;
      op_q    <= '0;
      pend_q  <= 1'b0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      spike_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick || pend_q) begin
            op_q   <= LEAK;
            pend_q <= 1'b0;
            state  <= ADD;
          end else if (in_if.in_valid) begin
            op_q  <= in_if.in_value;
            state <= ADD;
          end
        end
        ADD: begin
          v_q   <= add_a;
          state <= CHK;
          if (tick) pend_q <= 1'b1;
        end
        CHK: begin
          if (ge) begin
            spike_q <= 1'b1;
            v_q     <= V_RESET;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end
          state <= IDLE;
          if (tick) pend_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_spike_integrator.sv
// Self-checking bench for fp_spike_integrator with a real-valued float32 adder
// stand-in and a transaction-level membrane model.
module tb_fp_spike_integrator;

  localparam logic [31:0] LEAK = 32'hBC23_D70A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] add_b;
  logic [31:0] add_c;
  logic [31:0] add_a;
  logic [31:0] v_mem;
  logic        spike;
  logic [15:0] spike_cnt;
  logic        busy;

  fp_spike_integrator_if in_if ();

  fp_spike_integrator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (in_if.slave),
    .tick      (tick),
    .add_b     (add_b),
    .add_c     (add_c),
    .add_a     (add_a),
    .v_mem     (v_mem),
    .spike     (spike),
    .spike_cnt (spike_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int spk_seen = 0;
  int spk_exp = 0;

  task automatic check_val(string tag, logic [31:0] got,
                           logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real f2r(logic [31:0] f);
    logic [10:0] ex;
    if (f[30:23] == 8'd0) return 0.0;
    ex = {3'b0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], ex, f[22:0], 29'b0});
  endfunction

  // Double -> float32, round to nearest even, tiny values flush to zero.
  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [23:0] k;
    logic [28:0] rest;
    int          e;
    d = $realtobits(r);
    e = int'({21'b0, d[62:52]}) - 896;
    if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'b0};
    k = {1'b0, d[51:29]};
    rest = d[28:0];
    if (rest > 29'h1000_0000
        || (rest == 29'h1000_0000 && k[0])) k = k + 24'd1;
    if (k[23]) begin
      k = '0;
      e++;
    end
    return {d[63], e[7:0], k[22:0]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] x,
                                       logic [31:0] y);
    return r2f(f2r(x) + f2r(y));
  endfunction

  // Combinational adder stand-in on the operand bus.
  always_comb add_a = fadd(add_b, add_c);

  always @(negedge clk) if (spike) spk_seen++;

  // Reference membrane state.
  logic [31:0] m_v;
  logic [15:0] m_cnt;

  task automatic model_add(logic [31:0] x);
    m_v = fadd(m_v, x);
    if (f2r(m_v) >= 1.0) begin
      m_v = 32'h0;
      spk_exp++;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick = 1'b0;
    in_if.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_v = 32'h0;
    m_cnt = 16'h0;
  endtask

  // Returns at the negedge right after the accepting edge.
  task automatic send(logic [31:0] val);
    bit ok = 0;
    in_if.in_valid = 1'b1;
    in_if.in_value = val;
    for (int i = 0; i < 20; i++) begin
      if (in_if.in_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_if.in_valid = 1'b0;
    if (!ok) check_val("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy && in_if.in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_val("idle_timeout", 0, 1);
  endtask

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_value = 32'h0;
    do_reset();

    check_val("rst_v", v_mem, 32'h0);
    check_val("rst_spike", {31'b0, spike}, 0);
    check_val("rst_cnt", {16'b0, spike_cnt}, 0);
    check_val("rst_ready", {31'b0, in_if.in_ready}, 1);
    check_val("rst_busy", {31'b0, busy}, 0);

    // Two halves reach threshold exactly.
    send(32'h3F00_0000);
    check_val("busy_add", {31'b0, busy}, 1);
    @(negedge clk);
    check_val("half_v", v_mem, 32'h3F00_0000);
    @(negedge clk);
    check_val("half_nospk", {31'b0, spike}, 0);
    send(32'h3F00_0000);
    @(negedge clk);
    check_val("one_v", v_mem, 32'h3F80_0000);
    @(negedge clk);
    check_val("one_spk", {31'b0, spike}, 1);
    check_val("one_vrst", v_mem, 32'h0);
    check_val("one_cnt", {16'b0, spike_cnt}, 1);
    spk_exp++;
    @(negedge clk);
    check_val("one_pulse", {31'b0, spike}, 0);

    // Tick while busy becomes a pending leak.
    send(32'h3F40_0000);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_val("pend_rdy_chk", {31'b0, in_if.in_ready}, 0);
    @(negedge clk);
    check_val("pend_rdy_idle", {31'b0, in_if.in_ready}, 0);
    check_val("pend_busy", {31'b0, busy}, 0);
    @(negedge clk);
    check_val("pend_leak_busy", {31'b0, busy}, 1);
    wait_idle();
    check_val("pend_v", v_mem, 32'h3F3D_70A4);

    // Tick and valid together: leak first, input later.
    do_reset();
    in_if.in_valid = 1'b1;
    in_if.in_value = 32'h3E80_0000;
    tick = 1'b1;
    #1;
    check_val("tv_ready", {31'b0, in_if.in_ready}, 0);
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    check_val("tv_leak_v", v_mem, LEAK);
    @(negedge clk);
    check_val("tv_ready_late", {31'b0, in_if.in_ready}, 1);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    check_val("tv_accept", {31'b0, busy}, 1);
    wait_idle();
    check_val("tv_v", v_mem, fadd(LEAK, 32'h3E80_0000));

    // Equality with threshold fires.
    do_reset();
    send(32'hBF80_0000);
    wait_idle();
    send(32'h4000_0000);
    @(negedge clk);
    check_val("eq_v", v_mem, 32'h3F80_0000);
    @(negedge clk);
    check_val("eq_spk", {31'b0, spike}, 1);
    check_val("eq_vrst", v_mem, 32'h0);
    spk_exp++;

    // Reset in ADD discards the addition and the tick.
    do_reset();
    send(32'h3F00_0000);
    tick = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    tick = 1'b0;
    rst_n = 1'b1;
    check_val("radd_busy", {31'b0, busy}, 0);
    check_val("radd_v", v_mem, 32'h0);
    // Reset in CHK with a pending tick clears it.
    send(32'h3F00_0000);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("rchk_v", v_mem, 32'h0);
    check_val("rchk_spk", {31'b0, spike}, 0);
    check_val("rchk_ready", {31'b0, in_if.in_ready}, 1);
    repeat (4) @(negedge clk);
    check_val("rchk_noleak", v_mem, 32'h0);

    // Saturating counter.
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    send(32'h3F80_0000);
    wait_idle();
    spk_exp++;
    check_val("sat_cnt", {16'b0, spike_cnt}, 32'h0000_FFFF);

    // Randomized contributions and ticks.
    do_reset();
    for (int it = 0; it < 80; it++) begin
      int          k;
      int          mode;
      logic [31:0] x;
      k = int'($urandom_range(1500, 0));
      mode = int'($urandom_range(3, 0));
      x = r2f(real'(k - 600) / 1000.0);
      if (mode == 3) begin
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model_add(LEAK);
        wait_idle();
      end
      send(x);
      model_add(x);
      if (mode == 1 || mode == 2) begin
        tick = 1'b1;
        @(negedge clk);
        if (mode == 2) @(negedge clk);
        tick = 1'b0;
        model_add(LEAK);
      end
      wait_idle();
      check_val($sformatf("rnd_v%0d", it), v_mem, m_v);
      check_val($sformatf("rnd_cnt%0d", it),
                {16'b0, spike_cnt}, {16'b0, m_cnt});
    end

    @(negedge clk);
    check_val("spike_pulses", spk_seen, spk_exp);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
